cnt_en_gen: RTL
===============

# cnt_en_gen

Upstream control stage for the 6-bit counterA: turns two raw push-buttons (run/stop toggle and single-step) into the one-cycle `cnt_en` strobe the counter consumes. Raw inputs are synchronized, debounced and edge-detected. A small FSM then emits either a periodic prescaled strobe (run mode) or exactly one strobe per step press. `cnt_en` drives counterA's `cnt_en` directly; both blocks share `clk` and `reset`.

## Interface
- `PRESCALE`, 4: `cnt_en` period in clocks while running; legal range 2..65535.
- `DEB_LEN`, 3: consecutive stable cycles needed before a synchronized button level is accepted; legal range ≥1.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset: 0 clears all state immediately; deassertion is synchronous to `clk` upstream.
- `run_btn`  in  1  raw, asynchronous run/stop button, active-high.
- `step_btn`  in  1  raw, asynchronous single-step button, active-high.
- `cnt_en`  out  1  registered one-cycle count strobe to counterA.
- `running`  out  1  registered; 1 while FSM is in RUN.

## Operation
- Per button: 2-FF synchronizer, debouncer, then rising-edge detect of the debounced level. The result is a one-cycle `press`.
- Debouncer:
  - Counter width $clog2(DEB_LEN+1).
  - Increments each cycle the synchronized level differs from the debounced level; clears when they match.
  - The debounced level flips on the edge where the counter would reach DEB_LEN.
- Holding a button produces one press. A new press needs a debounced release first.
- FSM states: IDLE=0, RUN=1, STEP=2.
  - IDLE: run press → RUN, prescaler←0. Step press (no run press) → STEP, `cnt_en`←1. Simultaneous presses: run wins and the step press is dropped.
  - RUN: prescaler (width $clog2(PRESCALE)) counts 0..PRESCALE-1. When it is at PRESCALE-1 it wraps to 0 and `cnt_en`←1 for one cycle. A run press → IDLE, prescaler←0, `cnt_en`←0. If a run press coincides with prescaler==PRESCALE-1, stop wins and no strobe is emitted. Step presses are ignored.
  - STEP: unconditionally → IDLE next edge, `cnt_en`←0. Presses arriving in STEP are ignored.
- `cnt_en` is never high for two consecutive cycles.
- Reset values: state IDLE, `cnt_en`=0, `running`=0. Prescaler, synchronizers, debounce counters, debounced levels and edge registers all 0.
- Reset mid-operation clears all of the above asynchronously, including a strobe in flight.

## Timing
- Edge k is the first edge sampling a raw rising level.
  - Synchronized level is high after k+1.
  - Debounced level is high after k+1+DEB_LEN.
  - FSM transition happens at edge k+2+DEB_LEN.
- RUN: first `cnt_en` high after edge E+PRESCALE, where E is the RUN entry edge. Subsequent strobes every PRESCALE edges.
- STEP: `cnt_en` high for exactly the cycle following the STEP entry edge.
- `running` changes on the same edge as the state.

## Configuration
- `CNT_EN_GEN_DEBOUNCE_EN` defined: debouncer present as described.
- Undefined:
  - Debouncer removed; the synchronized level feeds the edge detect directly.
  - `DEB_LEN` is ignored.
  - Press-to-transition latency becomes edge k+3.
  - Glitches of one sampled cycle register as presses.

## Structure
- Package `cnt_en_gen_pkg`: FSM state typedef (IDLE/RUN/STEP, 2-bit encoding above), and default constants for PRESCALE and DEB_LEN.
- Sub-module `btn_cond`: synchronizer + debouncer + rising-edge detect. Parameter DEB_LEN; ports `clk`, `reset`, `raw`, `press`. Instantiated once per button. It contains the `CNT_EN_GEN_DEBOUNCE_EN` conditional.

## Test plan
All scenarios use PRESCALE=4, DEB_LEN=3, macro defined.
- Reset and idle: hold `reset`=0 5 cycles, release, 100 idle cycles → `cnt_en`=0 and `running`=0 throughout.
- Run and glitch rejection:
  - `run_btn` high 2 cycles (a glitch) → no state change.
  - `run_btn` high 10 cycles from edge k → `running`=1 after k+5.
  - `cnt_en` single-cycle pulses after k+9, k+13, k+17. counterA increments once per pulse.
- Stop and restart:
  - Second run press in RUN → `running`=0 and no further `cnt_en`.
  - Third press → first strobe exactly 4 edges after re-entry.
  - A stop press on the prescaler==3 cycle → no strobe.
- Step:
  - `step_btn` held 20 cycles in IDLE → exactly one `cnt_en` cycle.
  - Step press while RUN → strobe cadence unchanged.
  - run+step pressed simultaneously in IDLE → RUN and no step strobe.
- Reset mid-run: drive `reset`=0 during a `cnt_en`=1 cycle → `cnt_en` and `running` drop to 0 before the next edge. After release, `cnt_en` stays 0 until a new run press.

Source files
------------

// File: rtl/cnt_en_gen_pkg.sv
// cnt_en_gen_pkg: FSM state type and default parameters shared by cnt_en_gen and btn_cond
package cnt_en_gen_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STEP = 2'd2
   } state_t;

   localparam int PRESCALE_DEF = 4;
   localparam int DEB_LEN_DEF  = 3;

endpackage

// File: rtl/btn_cond.sv
// btn_cond: synchronizes, optionally debounces (CNT_EN_GEN_DEBOUNCE_EN) and edge-detects one raw button
module btn_cond
   import cnt_en_gen_pkg::*;
#(
   parameter int DEB_LEN = DEB_LEN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic press
);

   logic [1:0] sync;
   logic       lvl;
   logic       lvl_d;

   // two-flop synchronizer; sync[1] is the level safe to use in this clock domain
   always_ff @(posedge clk or negedge reset)
      if (!reset) sync <= '0;
      else sync <= {sync[0], raw};

`ifdef CNT_EN_GEN_DEBOUNCE_EN
   localparam int CW = $clog2(DEB_LEN + 1);
   localparam logic [CW-1:0] LAST = CW'(DEB_LEN - 1);

   logic [CW-1:0] cnt;

   // accept a new synchronized level only after it has differed for DEB_LEN consecutive cycles
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt <= '0;
         lvl <= 1'b0;
      end else if (sync[1] == lvl) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
         lvl <= sync[1];
      end else begin
         cnt <= cnt + 1'b1;
      end
`else
   // without debouncing the synchronized level is taken as-is, one register later
   always_ff @(posedge clk or negedge reset)
      if (!reset) lvl <= 1'b0;
      else lvl <= sync[1];
`endif

   // previous accepted level for rising-edge detection
   always_ff @(posedge clk or negedge reset)
      if (!reset) lvl_d <= 1'b0;
      else lvl_d <= lvl;

   assign press = lvl & ~lvl_d;

endmodule

// File: rtl/cnt_en_gen.sv
// cnt_en_gen: run/stop and single-step buttons to one-cycle cnt_en strobe; debouncer enabled by CNT_EN_GEN_DEBOUNCE_EN
module cnt_en_gen
   import cnt_en_gen_pkg::*;
#(
   parameter int PRESCALE = PRESCALE_DEF,
   parameter int DEB_LEN  = DEB_LEN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic run_btn,
   input  logic step_btn,
   output logic cnt_en,
   output logic running
);

   localparam int PW = $clog2(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   state_t          state;
   state_t          state_nx;
   logic [PW-1:0]   presc;
   logic [PW-1:0]   presc_nx;
   logic            cnt_en_nx;
   logic            run_press;
   logic            step_press;

   btn_cond #(.DEB_LEN(DEB_LEN)) u_run (
      .clk   (clk),
      .reset (reset),
      .raw   (run_btn),
      .press (run_press)
   );

   btn_cond #(.DEB_LEN(DEB_LEN)) u_step (
      .clk   (clk),
      .reset (reset),
      .raw   (step_btn),
      .press (step_press)
   );

   // next state, prescaler and strobe; run press beats step press and beats a due strobe
   always_comb begin
      state_nx  = state;
      presc_nx  = presc;
      cnt_en_nx = 1'b0;
      case (state)
         IDLE:
            if (run_press) begin
               state_nx = RUN;
               presc_nx = '0;
            end else if (step_press) begin
               state_nx  = STEP;
               cnt_en_nx = 1'b1;
            end
         RUN:
            if (run_press) begin
               state_nx = IDLE;
               presc_nx = '0;
            end else if (presc == LAST) begin
               presc_nx  = '0;
               cnt_en_nx = 1'b1;
            end else begin
               presc_nx = presc + 1'b1;
            end
         default:
            state_nx = IDLE;
      endcase
   end

   // state, prescaler and registered outputs
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state   <= IDLE;
         presc   <= '0;
         cnt_en  <= 1'b0;
         running <= 1'b0;
      end else begin
         state   <= state_nx;
         presc   <= presc_nx;
         cnt_en  <= cnt_en_nx;
         running <= (state_nx == RUN);
      end

endmodule
